// File: rtl/rpn_lan_msg_router.sv
// Packet-aware AXIS demultiplexer for the RPN LAN receive path.
// The message type on each header beat selects an output channel. That
// route stays locked until tlast. Outputs are registered through a
// main/skid buffer pair. Packets that match no route are discarded and
// counted.
module rpn_lan_msg_router #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_TDEST_WIDTH = 16,
  parameter int AXIS_TUSER_WIDTH = 16,
  parameter int NUM_OUTPUTS      = 3,
  parameter int MSG_TYPE_WIDTH   = 8,
  parameter int MSG_TYPE_LSB     = 0,
  parameter logic [NUM_OUTPUTS*MSG_TYPE_WIDTH-1:0] ROUTE_MATCH = {8'h03, 8'h01, 8'h00},
  parameter logic [NUM_OUTPUTS*MSG_TYPE_WIDTH-1:0] ROUTE_MASK  = {8'hFF, 8'hFF, 8'h01},
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_ap_rst_n,

  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [AXIS_TDEST_WIDTH-1:0] s_axis_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                        s_axis_tlast,

  output logic [NUM_OUTPUTS-1:0]      m_axis_tvalid,
  input  logic [NUM_OUTPUTS-1:0]      m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [AXIS_TDEST_WIDTH-1:0] m_axis_tid,
  output logic [AXIS_TDEST_WIDTH-1:0] m_axis_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        m_axis_tlast,

  output logic [DROP_CNT_WIDTH-1:0]   o_drop_count,
  output logic                        o_drop_pulse
);

  localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int PAY_W = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + 2 * AXIS_TDEST_WIDTH
                         + AXIS_TUSER_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t                    state_q;
  logic [SEL_W-1:0]          routeSel_q;
  logic [DROP_CNT_WIDTH-1:0] dropCount_q;
  logic                      dropPulse_q;

  logic                      mainValid_q, mainValid_d;
  logic [PAY_W-1:0]          mainPayload_q, mainPayload_d;
  logic [SEL_W-1:0]          mainSel_q, mainSel_d;
  logic                      skidValid_q, skidValid_d;
  logic [PAY_W-1:0]          skidPayload_q, skidPayload_d;
  logic [SEL_W-1:0]          skidSel_q, skidSel_d;
  logic                      inReady_q;

  logic [MSG_TYPE_WIDTH-1:0] msgType;
  logic                      hdrMatch;
  logic [SEL_W-1:0]          hdrSel;
  logic [SEL_W-1:0]          enqSel;
  logic [PAY_W-1:0]          inPayload;
  logic                      inAccept;
  logic                      enqueue;
  logic                      pop;
  logic                      dropLast;

  // Decode the type field of the current beat; the loop runs downwards so the lowest matching channel wins
  always_comb begin
    msgType  = s_axis_tdata[MSG_TYPE_LSB +: MSG_TYPE_WIDTH];
    hdrMatch = 1'b0;
    hdrSel   = '0;
    for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
      if ((msgType & ROUTE_MASK[i*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH]) ==
          (ROUTE_MATCH[i*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH] &
           ROUTE_MASK[i*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH])) begin
        hdrMatch = 1'b1;
        hdrSel   = SEL_W'(i);
      end
    end
  end

  // A dropped packet never waits on the outputs, so DROP overrides the buffer-space ready
  assign s_axis_tready = (state_q == ST_DROP) || inReady_q;
  assign inAccept      = s_axis_tvalid && s_axis_tready;
  assign inPayload     = {s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest,
                          s_axis_tuser, s_axis_tlast};
  assign enqueue       = inAccept && ((state_q == ST_FORWARD) ||
                                      (state_q == ST_HEADER && hdrMatch));
  assign enqSel        = (state_q == ST_HEADER) ? hdrSel : routeSel_q;
  assign dropLast      = inAccept && s_axis_tlast &&
                         ((state_q == ST_DROP) || (state_q == ST_HEADER && !hdrMatch));
  assign pop           = mainValid_q && m_axis_tready[mainSel_q];

  // Packet FSM: locks the route on the header, tracks drops and keeps the saturating drop counter
  always_ff @(posedge i_clk) begin
    if (!i_ap_rst_n) begin
      state_q     <= ST_HEADER;
      routeSel_q  <= '0;
      dropCount_q <= '0;
      dropPulse_q <= 1'b0;
    end else begin
      dropPulse_q <= dropLast;
      if (dropLast && (dropCount_q != {DROP_CNT_WIDTH{1'b1}})) begin
        dropCount_q <= dropCount_q + DROP_CNT_WIDTH'(1);
      end
      if (inAccept) begin
        unique case (state_q)
          ST_HEADER: begin
            if (hdrMatch) begin
              routeSel_q <= hdrSel;
              state_q    <= s_axis_tlast ? ST_HEADER : ST_FORWARD;
            end else begin
              state_q    <= s_axis_tlast ? ST_HEADER : ST_DROP;
            end
          end
          ST_FORWARD: if (s_axis_tlast) state_q <= ST_HEADER;
          ST_DROP:    if (s_axis_tlast) state_q <= ST_HEADER;
          default:    state_q <= ST_HEADER;
        endcase
      end
    end
  end

  // Main/skid buffer next state. The skid register only fills when the main register is held by a stalled consumer.
  always_comb begin
    mainValid_d   = mainValid_q;
    mainPayload_d = mainPayload_q;
    mainSel_d     = mainSel_q;
    skidValid_d   = skidValid_q;
    skidPayload_d = skidPayload_q;
    skidSel_d     = skidSel_q;
    if (enqueue) begin
      if (!mainValid_q || pop) begin
        mainValid_d   = 1'b1;
        mainPayload_d = inPayload;
        mainSel_d     = enqSel;
      end else begin
        skidValid_d   = 1'b1;
        skidPayload_d = inPayload;
        skidSel_d     = enqSel;
      end
    end else if (pop) begin
      if (skidValid_q) begin
        mainPayload_d = skidPayload_q;
        mainSel_d     = skidSel_q;
        skidValid_d   = 1'b0;
      end else begin
        mainValid_d   = 1'b0;
      end
    end
  end

  // Buffer registers. Only the valid flags and input ready need reset; payload contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    mainPayload_q <= mainPayload_d;
    mainSel_q     <= mainSel_d;
    skidPayload_q <= skidPayload_d;
    skidSel_q     <= skidSel_d;
    if (!i_ap_rst_n) begin
      mainValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
    end else begin
      mainValid_q <= mainValid_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= !skidValid_d;
    end
  end

  assign m_axis_tvalid = mainValid_q ? (NUM_OUTPUTS'(1) << mainSel_q) : '0;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tdest,
          m_axis_tuser, m_axis_tlast} = mainPayload_q;
  assign o_drop_count  = dropCount_q;
  assign o_drop_pulse  = dropPulse_q;

endmodule
